// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    localparam logic [MASK_W-1:0] MASK_ALL = 4'b1111;

    // Owner of the access issued in the previous cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IRD  = 2'd1,
        DRD  = 2'd2,
        DWR  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: data has priority,
// a starvation counter forces a fetch grant after STARVE_MAX denied cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ireq,
    input  logic [ADDR_W-1:0] i_iaddr,
    output logic              o_igrant,
    output logic              o_irvalid,
    output logic [DATA_W-1:0] o_irdata,
    input  logic              i_dreq,
    input  logic [ADDR_W-1:0] i_daddr,
    input  logic              i_dwe,
    input  logic [MASK_W-1:0] i_dmask,
    input  logic [DATA_W-1:0] i_dwdata,
    output logic              o_dgrant,
    output logic              o_drvalid,
    output logic [DATA_W-1:0] o_drdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [MASK_W-1:0] o_mem_mask,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             igrant_c;
    logic             dgrant_c;

    // Priority arbitration: starved fetch, then data, then fetch.
    always_comb begin
        igrant_c = 1'b0;
        dgrant_c = 1'b0;
        if (i_ireq && (starve_q == STARVE_LIMIT)) begin
            igrant_c = 1'b1;
        end else if (i_dreq) begin
            dgrant_c = 1'b1;
        end else if (i_ireq) begin
            igrant_c = 1'b1;
        end
        o_igrant = igrant_c;
        o_dgrant = dgrant_c;
    end

    // Drive the RAM from the granted requester; quiet bus when nothing is granted.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_mask  = '0;
        o_mem_wdata = '0;
        if (igrant_c) begin
            o_mem_addr = i_iaddr;
            o_mem_mask = MASK_ALL;
        end else if (dgrant_c) begin
            o_mem_addr  = i_daddr;
            o_mem_we    = i_dwe;
            o_mem_mask  = i_dwe ? i_dmask : MASK_ALL;
            o_mem_wdata = i_dwdata;
        end
    end

    // Next owner of the RAM response and next starvation count.
    always_comb begin
        state_d  = IDLE;
        starve_d = '0;
        if (igrant_c) begin
            state_d = IRD;
        end else if (dgrant_c) begin
            state_d = i_dwe ? DWR : DRD;
        end
        if (i_ireq && !igrant_c) begin
            starve_d = (starve_q == STARVE_LIMIT) ? starve_q : starve_q + CNT_W'(1);
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Steer the RAM read data to whichever port owns the in-flight read.
    always_comb begin
        o_irvalid = (state_q == IRD);
        o_drvalid = (state_q == DRD);
        o_irdata  = o_irvalid ? i_mem_rdata : '0;
        o_drdata  = o_drvalid ? i_mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// compared each cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned SM = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq, dreq, dwe;
    logic [29:0] iaddr, daddr;
    logic [3:0]  dmask;
    logic [31:0] dwdata;
    logic        o_igrant, o_irvalid, o_dgrant, o_drvalid;
    logic [31:0] o_irdata, o_drdata;
    logic [29:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_mem_mask;
    logic [31:0] o_mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] ref_mem [logic [29:0]];
    int          wait_cnt = 0;
    int          exp_resp = 0;      // 0 none, 1 fetch, 2 data
    logic [31:0] exp_rdata = 32'h0;
    logic        last_ig = 1'b0;
    logic        last_dg = 1'b0;

    // RAM behavioural model.
    logic [31:0] ram [logic [29:0]];

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(SM), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ireq     (ireq),
        .i_iaddr    (iaddr),
        .o_igrant   (o_igrant),
        .o_irvalid  (o_irvalid),
        .o_irdata   (o_irdata),
        .i_dreq     (dreq),
        .i_daddr    (daddr),
        .i_dwe      (dwe),
        .i_dmask    (dmask),
        .i_dwdata   (dwdata),
        .o_dgrant   (o_dgrant),
        .o_drvalid  (o_drvalid),
        .o_drdata   (o_drdata),
        .o_mem_addr (o_mem_addr),
        .o_mem_we   (o_mem_we),
        .o_mem_mask (o_mem_mask),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_val(input logic [29:0] a);
        return (32'(a) * 32'h9E3779B1) + 32'h1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ram_read(input logic [29:0] a);
        return ram.exists(a) ? ram[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Synchronous single-port RAM, one cycle read latency.
    always @(posedge clk) begin
        mem_rdata <= ram_read(o_mem_addr);
        if (o_mem_we) ram[o_mem_addr] = merge(ram_read(o_mem_addr), o_mem_wdata, o_mem_mask);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic ir, input logic [29:0] ia, input logic dr,
                          input logic [29:0] da, input logic we, input logic [3:0] m,
                          input logic [31:0] wd);
        ireq = ir; iaddr = ia; dreq = dr; daddr = da; dwe = we; dmask = m; dwdata = wd;
    endtask

    // One cycle: check outputs against the model, then advance the model and clock.
    task automatic step();
        logic        eig, edg;
        logic [29:0] ea;
        logic [3:0]  em;
        logic [31:0] ewd;
        #1;
        eig = ireq && ((wait_cnt == int'(SM)) || !dreq);
        edg = dreq && !eig;
        ea  = eig ? iaddr : (edg ? daddr : 30'h0);
        em  = eig ? 4'hF : (edg ? (dwe ? dmask : 4'hF) : 4'h0);
        ewd = edg ? dwdata : 32'h0;
        chk("igrant",    32'(o_igrant),    32'(eig));
        chk("dgrant",    32'(o_dgrant),    32'(edg));
        chk("mem_addr",  32'(o_mem_addr),  32'(ea));
        chk("mem_we",    32'(o_mem_we),    32'(edg && dwe));
        chk("mem_mask",  32'(o_mem_mask),  32'(em));
        chk("mem_wdata", o_mem_wdata,      ewd);
        chk("irvalid",   32'(o_irvalid),   32'(exp_resp == 1));
        chk("irdata",    o_irdata,         (exp_resp == 1) ? exp_rdata : 32'h0);
        chk("drvalid",   32'(o_drvalid),   32'(exp_resp == 2));
        chk("drdata",    o_drdata,         (exp_resp == 2) ? exp_rdata : 32'h0);
        last_ig = eig;
        last_dg = edg;
        if (eig) begin
            exp_resp  = 1;
            exp_rdata = ref_read(iaddr);
        end else if (edg && !dwe) begin
            exp_resp  = 2;
            exp_rdata = ref_read(daddr);
        end else begin
            exp_resp = 0;
        end
        if (edg && dwe) ref_mem[daddr] = merge(ref_read(daddr), dwdata, dmask);
        if (!rst_n) exp_resp = 0;
        if (!rst_n || !ireq || eig) wait_cnt = 0;
        else if (wait_cnt < int'(SM)) wait_cnt++;
        @(negedge clk);
    endtask

    function automatic logic [29:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 30'h3FFFFFFF;
        if (r == 1) return 30'h0;
        return 30'($urandom_range(0, 15));
    endfunction

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        step();
        rst_n = 1'b1;

        // Preload word 0x10 then fetch it.
        set_in(1'b0, 30'h0, 1'b1, 30'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        step();
        set_in(1'b1, 30'h10, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        step();
        chk("fetch_data", o_irdata, 32'hDEADBEEF);
        set_in(1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        step();

        // Collision: data wins three times, then the starved fetch.
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, 30'h10, 1'b1, 30'h4, 1'b0, 4'h0, 32'h0);
            step();
            chk("collide_pattern", 32'(last_ig), 32'((k % 4) == 3));
        end
        set_in(1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        step();

        // Masked write over a known word, then read it back.
        set_in(1'b0, 30'h0, 1'b1, 30'h4, 1'b1, 4'hF, 32'hAAAAAAAA);
        step();
        set_in(1'b0, 30'h0, 1'b1, 30'h4, 1'b1, 4'b0011, 32'h12345678);
        step();
        set_in(1'b0, 30'h0, 1'b1, 30'h4, 1'b0, 4'h0, 32'h0);
        step();
        chk("masked_read", o_drdata, 32'hAAAA5678);

        // Data read then fetch in consecutive cycles.
        set_in(1'b0, 30'h0, 1'b1, 30'h8, 1'b0, 4'h0, 32'h0);
        step();
        set_in(1'b1, 30'hC, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        step();
        set_in(1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        step();

        // Extreme addresses pass straight through.
        set_in(1'b0, 30'h0, 1'b1, 30'h3FFFFFFF, 1'b1, 4'hF, 32'h0BADF00D);
        step();
        set_in(1'b0, 30'h0, 1'b1, 30'h3FFFFFFF, 1'b0, 4'h0, 32'h0);
        step();
        chk("top_addr_read", o_drdata, 32'h0BADF00D);
        set_in(1'b1, 30'h0, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        step();

        // Fetch granted during reset: its response is dropped.
        rst_n = 1'b0;
        set_in(1'b1, 30'h10, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        step();
        rst_n = 1'b1;
        set_in(1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        step();
        chk("rst_irvalid", 32'(o_irvalid), 32'h0);
        chk("rst_irdata",  o_irdata,       32'h0);

        // Idle cycles.
        for (int k = 0; k < 5; k++) step();

        // Randomized traffic honouring the hold-until-grant protocol.
        for (int n = 0; n < 400; n++) begin
            if (!(ireq && !last_ig && ($urandom_range(0, 19) != 0))) begin
                ireq  = ($urandom_range(0, 1) == 1);
                iaddr = rand_addr();
            end
            if (!(dreq && !last_dg && ($urandom_range(0, 19) != 0))) begin
                dreq   = ($urandom_range(0, 1) == 1);
                daddr  = rand_addr();
                dwe    = ($urandom_range(0, 2) == 0);
                dmask  = 4'($urandom_range(0, 15));
                dwdata = $urandom;
            end
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
